reversi_accel_sdiv_28s_12s_16_seq: RTL and testbench

Sequential signed divider, the inverse of the accelerator's 16s×12s→28 pipelined multiplier. It takes a 28-bit signed dividend and a 12-bit signed divisor, and returns a 16-bit signed quotient and a 12-bit signed remainder using C truncating semantics. It is used in the evaluation datapath to rescale accumulated multiply products back to score width. One division is in flight at a time, with valid/ready handshakes on both sides and the codebase's `ce` stall input.

---
 rtl/reversi_accel_sdiv_28s_12s_16_seq.sv | 160 ++++++++++++++++
 tb/tb_reversi_accel_sdiv_28s_12s_16_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/reversi_accel_sdiv_28s_12s_16_seq.sv
// Sequential signed divider: 28s / 12s -> 16s saturated quotient, 12s remainder.
// Ports: clk, rst_n, ce, in_valid/in_ready + dividend/divisor, out_valid/out_ready + quotient/remainder/ovf/dz.
module reversi_accel_sdiv_28s_12s_16_seq #(
  parameter int ID = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ce,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [27:0] dividend,
  input  logic [11:0] divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [11:0] remainder,
  output logic        ovf,
  output logic        dz
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        dzsel_q, dzsel_d;
  logic [27:0] dvd_q, dvd_d;
  logic [11:0] dsr_q, dsr_d;
  logic [11:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] quo_q, quo_d;
  logic [11:0] rmd_q, rmd_d;
  logic        ovf_q, ovf_d;
  logic        dz_q, dz_d;

  logic        unused_id;
  assign unused_id = (ID != 0);

  // dvd_q holds |dividend| and fills with quotient bits from the LSB
  // as the dividend bits leave through the MSB.
  logic [12:0] rem_sh;
  logic        ge;
  logic        qneg;
  logic        q_big;

  assign rem_sh = {rem_q, dvd_q[27]};
  assign ge     = rem_sh >= {1'b0, dsr_q};
  assign qneg   = sa_q ^ sb_q;
  // Negative side reaches one further: -32768 is representable.
  assign q_big  = qneg ? (dvd_q > 28'd32768)
                       : (dvd_q > 28'd32767);

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    dzsel_d = dzsel_q;
    dvd_d   = dvd_q;
    dsr_d   = dsr_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    ovf_d   = ovf_q;
    dz_d    = dz_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sa_d    = dividend[27];
          sb_d    = divisor[11];
          dvd_d   = dividend[27] ? (~dividend + 28'd1)
                                 : dividend;
          dsr_d   = divisor[11] ? (~divisor + 12'd1)
                                : divisor;
          rem_d   = '0;
          cnt_d   = 5'd27;
          dzsel_d = (divisor == 12'd0);
          state_d = (divisor == 12'd0) ? S_FIX : S_CALC;
        end
      end
      S_CALC: begin
        rem_d = ge ? 12'(rem_sh - {1'b0, dsr_q})
                   : rem_sh[11:0];
        dvd_d = {dvd_q[26:0], ge};
        if (cnt_q == 5'd0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      S_FIX: begin
        dz_d  = dzsel_q;
        ovf_d = 1'b0;
        if (dzsel_q) begin
          quo_d = sa_q ? 16'h8000 : 16'h7fff;
          rmd_d = '0;
        end else begin
          if (q_big) begin
            quo_d = qneg ? 16'h8000 : 16'h7fff;
            ovf_d = 1'b1;
          end else begin
            quo_d = qneg ? (~dvd_q[15:0] + 16'd1)
                         : dvd_q[15:0];
          end
          rmd_d = sa_q ? (~rem_q + 12'd1) : rem_q;
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      dzsel_q <= 1'b0;
      dvd_q   <= '0;
      dsr_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      ovf_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else if (ce) begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      dzsel_q <= dzsel_d;
      dvd_q   <= dvd_d;
      dsr_q   <= dsr_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      ovf_q   <= ovf_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign quotient  = quo_q;
  assign remainder = rmd_q;
  assign ovf       = ovf_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_reversi_accel_sdiv_28s_12s_16_seq.sv
// Scoreboard bench for the sequential signed divider.
// Driver pushes model results; monitor pops on each output handshake.
module tb_reversi_accel_sdiv_28s_12s_16_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic        in_valid;
  logic        in_ready;
  logic [27:0] dividend;
  logic [11:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [11:0] remainder;
  logic        ovf;
  logic        dz;

  reversi_accel_sdiv_28s_12s_16_seq #(.ID(1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .ce(ce),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .dividend(dividend),
    .divisor(divisor),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .quotient(quotient),
    .remainder(remainder),
    .ovf(ovf),
    .dz(dz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] q;
    logic [11:0] r;
    logic        ovf;
    logic        dz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic exp_t model(longint a, longint b);
    exp_t   e;
    longint q;
    longint r;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    if (b == 0) begin
      e.dz = 1'b1;
      e.r  = '0;
      e.q  = (a >= 0) ? 16'h7fff : 16'h8000;
    end else begin
      q = a / b;
      r = a % b;
      if (q > 32767) begin
        q = 32767;
        e.ovf = 1'b1;
      end else if (q < -32768) begin
        q = -32768;
        e.ovf = 1'b1;
      end
      e.q = 16'(q);
      e.r = 12'(r);
    end
    return e;
  endfunction

  task automatic check(input string nm, input longint act,
                       input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ce && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", longint'(quotient), longint'(e.q));
        check("remainder", longint'(remainder), longint'(e.r));
        check("ovf", longint'(ovf), longint'(e.ovf));
        check("dz", longint'(dz), longint'(e.dz));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input longint a, input longint b);
    dividend = 28'(a);
    divisor  = 12'(b);
    in_valid = 1'b1;
    ce       = 1'b1;
    sb.push_back(model(a, b));
    tick();
    in_valid = 1'b0;
    dividend = 28'($urandom);
    divisor  = 12'($urandom);
  endtask

  task automatic wait_valid(output int cyc, input int s0,
                            input int s1, input bit rnd);
    cyc = 0;
    while (!out_valid && cyc < 300) begin
      if (rnd) ce = ($urandom_range(0, 3) != 0);
      if (cyc == s0) ce = 1'b0;
      if (cyc == s1) ce = 1'b1;
      tick();
      cyc++;
    end
    ce = 1'b1;
    if (!out_valid) check("valid_timeout", 0, 1);
  endtask

  task automatic drain(input bit rnd);
    int n;
    n = 0;
    while (!in_ready && n < 300) begin
      if (rnd) begin
        out_ready = $urandom_range(0, 1);
        ce = ($urandom_range(0, 3) != 0);
      end else begin
        out_ready = 1'b1;
      end
      tick();
      n++;
    end
    out_ready = 1'b1;
    ce = 1'b1;
    if (!in_ready) check("ready_timeout", 0, 1);
  endtask

  task automatic chk_zero(input string nm);
    check({nm, "_in_ready"}, longint'(in_ready), 1);
    check({nm, "_out_valid"}, longint'(out_valid), 0);
    check({nm, "_q"}, longint'(quotient), 0);
    check({nm, "_r"}, longint'(remainder), 0);
    check({nm, "_ovf"}, longint'(ovf), 0);
    check({nm, "_dz"}, longint'(dz), 0);
  endtask

  typedef struct {
    longint a;
    longint b;
    int     lat;
  } vec_t;

  initial begin
    int   cyc;
    exp_t e;
    vec_t v[$];
    rst_n     = 1'b0;
    ce        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    v.push_back('{1000, 7, 29});
    v.push_back('{-1000, 7, 29});
    v.push_back('{1000, -7, 29});
    v.push_back('{-134217728, -2048, 29});
    v.push_back('{134217727, 1, 29});
    v.push_back('{5, 0, 1});
    v.push_back('{-5, 0, 1});
    v.push_back('{-134217728, 2047, 29});
    v.push_back('{-32768, 1, 29});
    foreach (v[i]) begin
      start(v[i].a, v[i].b);
      wait_valid(cyc, -1, -1, 1'b0);
      check("latency", cyc, v[i].lat);
      drain(1'b0);
    end

    out_ready = 1'b0;
    start(12345, -77);
    e = model(12345, -77);
    wait_valid(cyc, -1, -1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      tick();
      check("bp_valid", longint'(out_valid), 1);
      check("bp_in_ready", longint'(in_ready), 0);
      check("bp_q", longint'(quotient), longint'(e.q));
      check("bp_r", longint'(remainder), longint'(e.r));
    end
    out_ready = 1'b1;
    tick();
    check("bp_release", longint'(in_ready), 1);

    start(30000, 3);
    wait_valid(cyc, 5, 10, 1'b0);
    check("stall_latency", cyc, 34);
    out_ready = 1'b1;
    ce = 1'b0;
    repeat (3) begin
      tick();
      check("ce_done_hold", longint'(out_valid), 1);
    end
    ce = 1'b1;
    drain(1'b0);

    start(5000, 3);
    repeat (12) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sb.delete();
    chk_zero("midreset");
    start(100, 10);
    wait_valid(cyc, -1, -1, 1'b0);
    check("post_reset_lat", cyc, 29);
    drain(1'b0);

    for (int n = 0; n < 50; n++) begin
      logic signed [27:0] t;
      logic signed [11:0] d;
      t = 28'($urandom);
      t = t >>> $urandom_range(0, 27);
      d = 12'($urandom);
      if ($urandom_range(0, 3) == 0) d = d >>> 8;
      if ($urandom_range(0, 11) == 0) d = '0;
      start(longint'(t), longint'(d));
      wait_valid(cyc, -1, -1, 1'b1);
      drain(1'b1);
    end

    repeat (4) tick();
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
